// File: rtl/ap_channel_profiler_if.sv
// Block-level handshake bundle observed by ap_channel_profiler: one bit per channel
// for ap_start/ap_ready/ap_done/ap_continue and the loop-iteration strobe.
interface ap_channel_profiler_if #(
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic [NUM_CH-1:0] iter_valid;

    modport master (output ap_start, ap_ready, ap_done, ap_continue, iter_valid);
    modport slave  (input  ap_start, ap_ready, ap_done, ap_continue, iter_valid);
endinterface

// File: rtl/ap_channel_profiler.sv
// Per-channel saturating statistics for HLS ap_ctrl handshakes with a registered readout port.
// Optional macro PROFILER_STALL_EN adds per-channel DONE_WAIT (stall) counters.
module ap_channel_profiler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int LAT_W  = 16,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ap_channel_profiler_if.slave   ch_if,
    input  logic                   clear_i,
    input  logic                   finish_i,
    input  logic [SEL_W-1:0]       rd_sel_i,
    output logic [CNT_W-1:0]       rd_txn_o,
    output logic [CNT_W-1:0]       rd_busy_o,
    output logic [CNT_W-1:0]       rd_iter_o,
    output logic [CNT_W-1:0]       rd_stall_o,
    output logic [LAT_W-1:0]       rd_last_lat_o,
    output logic [LAT_W-1:0]       rd_max_lat_o,
    output logic [1:0]             rd_state_o,
    output logic                   rd_err_o,
    output logic                   any_err_o,
    output logic                   frozen_o
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BUSY      = 2'd1;
    localparam logic [1:0] ST_DONE_WAIT = 2'd2;
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                frozen_q;
    logic [1:0]          state_a    [NUM_CH];
    logic [CNT_W-1:0]    txn_a      [NUM_CH];
    logic [CNT_W-1:0]    busy_a     [NUM_CH];
    logic [CNT_W-1:0]    iter_a     [NUM_CH];
    logic [LAT_W-1:0]    last_lat_a [NUM_CH];
    logic [LAT_W-1:0]    max_lat_a  [NUM_CH];
    logic [NUM_CH-1:0]   err_a;
`ifdef PROFILER_STALL_EN
    logic [CNT_W-1:0]    stall_a    [NUM_CH];
`endif

    // clear wins over finish and is the only non-reset way out of the frozen state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frozen_q <= 1'b0;
        end else if (clear_i) begin
            frozen_q <= 1'b0;
        end else if (finish_i) begin
            frozen_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]       state_q, state_d;
            logic [LAT_W-1:0] lat_q, lat_d;
            logic [CNT_W-1:0] txn_q, txn_d;
            logic [CNT_W-1:0] busy_q, busy_d;
            logic [CNT_W-1:0] iter_q, iter_d;
            logic [LAT_W-1:0] last_q, last_d;
            logic [LAT_W-1:0] max_q, max_d;
            logic             err_q, err_d;
            logic             cpl;
            logic [LAT_W-1:0] cpl_lat;
`ifdef PROFILER_STALL_EN
            logic [CNT_W-1:0] stall_q, stall_d;
`endif

            always_comb begin
                state_d = state_q;
                lat_d   = lat_q;
                txn_d   = txn_q;
                busy_d  = busy_q;
                iter_d  = iter_q;
                last_d  = last_q;
                max_d   = max_q;
                err_d   = err_q;
                cpl     = 1'b0;
                cpl_lat = '0;
`ifdef PROFILER_STALL_EN
                stall_d = stall_q;
`endif
                if (clear_i) begin
                    // FSM keeps its state; an in-flight latency restarts from zero
                    lat_d  = '0;
                    txn_d  = '0;
                    busy_d = '0;
                    iter_d = '0;
                    last_d = '0;
                    max_d  = '0;
                    err_d  = 1'b0;
`ifdef PROFILER_STALL_EN
                    stall_d = '0;
`endif
                end else if (!frozen_q) begin
                    if (state_q != ST_IDLE)
                        busy_d = cnt_inc(busy_q);
                    if (ch_if.iter_valid[gi])
                        iter_d = cnt_inc(iter_q);
`ifdef PROFILER_STALL_EN
                    if (state_q == ST_DONE_WAIT)
                        stall_d = cnt_inc(stall_q);
`endif
                    case (state_q)
                        ST_IDLE: begin
                            if (ch_if.ap_start[gi]) begin
                                lat_d = LAT_ONE;
                                if (ch_if.ap_done[gi]) begin
                                    cpl     = 1'b1;
                                    cpl_lat = LAT_ONE;
                                    state_d = ch_if.ap_continue[gi] ? ST_IDLE : ST_DONE_WAIT;
                                end else begin
                                    state_d = ST_BUSY;
                                end
                            end else if (ch_if.ap_done[gi] || ch_if.ap_ready[gi]) begin
                                err_d = 1'b1;
                            end
                        end
                        ST_BUSY: begin
                            if (ch_if.ap_done[gi]) begin
                                cpl     = 1'b1;
                                cpl_lat = lat_inc(lat_q);
                                state_d = ch_if.ap_continue[gi] ? ST_IDLE : ST_DONE_WAIT;
                            end else begin
                                lat_d = lat_inc(lat_q);
                            end
                        end
                        ST_DONE_WAIT: begin
                            if (ch_if.ap_continue[gi])
                                state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                    if (cpl) begin
                        txn_d  = cnt_inc(txn_q);
                        last_d = cpl_lat;
                        if (cpl_lat > max_q)
                            max_d = cpl_lat;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= ST_IDLE;
                    lat_q   <= '0;
                    txn_q   <= '0;
                    busy_q  <= '0;
                    iter_q  <= '0;
                    last_q  <= '0;
                    max_q   <= '0;
                    err_q   <= 1'b0;
`ifdef PROFILER_STALL_EN
                    stall_q <= '0;
`endif
                end else begin
                    state_q <= state_d;
                    lat_q   <= lat_d;
                    txn_q   <= txn_d;
                    busy_q  <= busy_d;
                    iter_q  <= iter_d;
                    last_q  <= last_d;
                    max_q   <= max_d;
                    err_q   <= err_d;
`ifdef PROFILER_STALL_EN
                    stall_q <= stall_d;
`endif
                end
            end

            assign state_a[gi]    = state_q;
            assign txn_a[gi]      = txn_q;
            assign busy_a[gi]     = busy_q;
            assign iter_a[gi]     = iter_q;
            assign last_lat_a[gi] = last_q;
            assign max_lat_a[gi]  = max_q;
            assign err_a[gi]      = err_q;
`ifdef PROFILER_STALL_EN
            assign stall_a[gi]    = stall_q;
`endif
        end
    endgenerate

    // Registered readout; out-of-range selects read as all zeros
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_txn_o      <= '0;
            rd_busy_o     <= '0;
            rd_iter_o     <= '0;
            rd_last_lat_o <= '0;
            rd_max_lat_o  <= '0;
            rd_state_o    <= ST_IDLE;
            rd_err_o      <= 1'b0;
`ifdef PROFILER_STALL_EN
            rd_stall_o    <= '0;
`endif
        end else if (int'(rd_sel_i) < NUM_CH) begin
            rd_txn_o      <= txn_a[rd_sel_i];
            rd_busy_o     <= busy_a[rd_sel_i];
            rd_iter_o     <= iter_a[rd_sel_i];
            rd_last_lat_o <= last_lat_a[rd_sel_i];
            rd_max_lat_o  <= max_lat_a[rd_sel_i];
            rd_state_o    <= state_a[rd_sel_i];
            rd_err_o      <= err_a[rd_sel_i];
`ifdef PROFILER_STALL_EN
            rd_stall_o    <= stall_a[rd_sel_i];
`endif
        end else begin
            rd_txn_o      <= '0;
            rd_busy_o     <= '0;
            rd_iter_o     <= '0;
            rd_last_lat_o <= '0;
            rd_max_lat_o  <= '0;
            rd_state_o    <= ST_IDLE;
            rd_err_o      <= 1'b0;
`ifdef PROFILER_STALL_EN
            rd_stall_o    <= '0;
`endif
        end
    end

`ifndef PROFILER_STALL_EN
    assign rd_stall_o = '0;
`endif

    assign any_err_o = |err_a;
    assign frozen_o  = frozen_q;
endmodule

// File: tb/tb_ap_channel_profiler.sv
// Directed bench for ap_channel_profiler: a default instance (4 ch, 32/16-bit) and a
// narrow instance (3 ch, 4-bit counters/latency) for saturation and out-of-range reads.
module tb_ap_channel_profiler;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    ap_channel_profiler_if #(.NUM_CH(4)) if_a ();
    ap_channel_profiler_if #(.NUM_CH(3)) if_b ();

    logic        clear_a, finish_a;
    logic [1:0]  sel_a;
    logic [31:0] txn_a, busy_a, iter_a, stall_a;
    logic [15:0] last_a, max_a;
    logic [1:0]  state_a;
    logic        err_a, any_a, frozen_a;

    logic        clear_b, finish_b;
    logic [1:0]  sel_b;
    logic [3:0]  txn_b, busy_b, iter_b, stall_b;
    logic [3:0]  last_b, max_b;
    logic [1:0]  state_b;
    logic        err_b, any_b, frozen_b;

    ap_channel_profiler #(.NUM_CH(4), .CNT_W(32), .LAT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .ch_if(if_a.slave),
        .clear_i(clear_a), .finish_i(finish_a), .rd_sel_i(sel_a),
        .rd_txn_o(txn_a), .rd_busy_o(busy_a), .rd_iter_o(iter_a), .rd_stall_o(stall_a),
        .rd_last_lat_o(last_a), .rd_max_lat_o(max_a), .rd_state_o(state_a),
        .rd_err_o(err_a), .any_err_o(any_a), .frozen_o(frozen_a)
    );

    ap_channel_profiler #(.NUM_CH(3), .CNT_W(4), .LAT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .ch_if(if_b.slave),
        .clear_i(clear_b), .finish_i(finish_b), .rd_sel_i(sel_b),
        .rd_txn_o(txn_b), .rd_busy_o(busy_b), .rd_iter_o(iter_b), .rd_stall_o(stall_b),
        .rd_last_lat_o(last_b), .rd_max_lat_o(max_b), .rd_state_o(state_b),
        .rd_err_o(err_b), .any_err_o(any_b), .frozen_o(frozen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_stall;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        clear_a = 0; finish_a = 0; sel_a = 0;
        clear_b = 0; finish_b = 0; sel_b = 0;
        if_a.ap_start = '0; if_a.ap_ready = '0; if_a.ap_done = '0;
        if_a.ap_continue = 4'b1011; if_a.iter_valid = '0;
        if_b.ap_start = '0; if_b.ap_ready = '0; if_b.ap_done = '0;
        if_b.ap_continue = 3'b111; if_b.iter_valid = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_txn", txn_a, 0);
        check("reset_state", state_a, 0);
        check("reset_any_err", any_a, 0);
        check("reset_frozen", frozen_a, 0);

        // ch0: 5-cycle transaction with 3 iteration pulses
        sel_a = 0;
        if_a.ap_start[0] = 1; if_a.iter_valid[0] = 1;
        tick(1);
        if_a.ap_start[0] = 0;
        tick(2);
        if_a.iter_valid[0] = 0;
        tick(1);
        if_a.ap_done[0] = 1;
        tick(1);
        if_a.ap_done[0] = 0;
        tick(1);
        check("ch0_txn", txn_a, 1);
        check("ch0_last_lat", last_a, 5);
        check("ch0_max_lat", max_a, 5);
        check("ch0_busy", busy_a, 4);
        check("ch0_iter", iter_a, 3);
        check("ch0_state", state_a, 0);

        // ch1: three back-to-back single-cycle transactions
        if_a.ap_start[1] = 1; if_a.ap_done[1] = 1;
        tick(3);
        if_a.ap_start[1] = 0; if_a.ap_done[1] = 0;
        sel_a = 1;
        tick(1);
        check("ch1_txn", txn_a, 3);
        check("ch1_last_lat", last_a, 1);
        check("ch1_max_lat", max_a, 1);
        check("ch1_busy", busy_a, 0);

        // ch2: done with continue held low for 6 cycles
        sel_a = 2;
        if_a.ap_start[2] = 1;
        tick(1);
        if_a.ap_start[2] = 0;
        tick(2);
        if_a.ap_done[2] = 1;
        tick(1);
        if_a.ap_done[2] = 0;
        tick(1);
        check("ch2_state_done_wait", state_a, 2);
        tick(4);
        if_a.ap_continue[2] = 1;
        tick(1);
        tick(1);
`ifdef PROFILER_STALL_EN
        exp_stall = 6;
`else
        exp_stall = 0;
`endif
        check("ch2_txn", txn_a, 1);
        check("ch2_last_lat", last_a, 4);
        check("ch2_busy", busy_a, 9);
        check("ch2_stall", stall_a, exp_stall);
        check("ch2_state_idle", state_a, 0);

        // ch3: done while idle is a protocol error, cleared by clear
        if_a.ap_done[3] = 1;
        tick(1);
        if_a.ap_done[3] = 0;
        sel_a = 3;
        tick(1);
        check("ch3_err", err_a, 1);
        check("ch3_any_err", any_a, 1);
        clear_a = 1;
        tick(1);
        clear_a = 0;
        tick(1);
        check("clear_ch3_err", err_a, 0);
        check("clear_any_err", any_a, 0);
        sel_a = 0;
        tick(1);
        check("clear_ch0_txn", txn_a, 0);
        check("clear_ch0_busy", busy_a, 0);
        check("clear_ch0_iter", iter_a, 0);

        // finish freezes statistics
        if_a.ap_start[0] = 1; if_a.ap_done[0] = 1;
        tick(1);
        if_a.ap_start[0] = 0; if_a.ap_done[0] = 0;
        finish_a = 1;
        tick(1);
        finish_a = 0;
        check("finish_frozen", frozen_a, 1);
        if_a.ap_start[0] = 1; if_a.ap_done[0] = 1; if_a.iter_valid[0] = 1;
        tick(2);
        if_a.ap_start[0] = 0; if_a.ap_done[0] = 0; if_a.iter_valid[0] = 0;
        tick(1);
        check("frozen_txn", txn_a, 1);
        check("frozen_iter", iter_a, 0);
        clear_a = 1; finish_a = 1;
        tick(1);
        clear_a = 0; finish_a = 0;
        check("clear_over_finish_frozen", frozen_a, 0);

        // narrow instance: latency and counter saturation
        sel_b = 0;
        if_b.ap_start[0] = 1;
        tick(1);
        if_b.ap_start[0] = 0;
        tick(18);
        if_b.ap_done[0] = 1;
        tick(1);
        if_b.ap_done[0] = 0;
        tick(1);
        check("sat_txn", txn_b, 1);
        check("sat_last_lat", last_b, 15);
        check("sat_max_lat", max_b, 15);
        check("sat_busy", busy_b, 15);
        if_b.iter_valid[1] = 1;
        tick(20);
        if_b.iter_valid[1] = 0;
        sel_b = 1;
        tick(1);
        check("sat_iter", iter_b, 15);
        if_b.ap_ready[2] = 1;
        tick(1);
        if_b.ap_ready[2] = 0;
        sel_b = 2;
        tick(1);
        check("ready_idle_err", err_b, 1);
        check("ready_idle_any_err", any_b, 1);
        sel_b = 3;
        tick(1);
        check("oob_txn", txn_b, 0);
        check("oob_busy", busy_b, 0);
        check("oob_iter", iter_b, 0);
        check("oob_last_lat", last_b, 0);
        check("oob_max_lat", max_b, 0);
        check("oob_state", state_b, 0);
        check("oob_err", err_b, 0);

        // async reset in the middle of a BUSY transaction
        sel_a = 0;
        if_a.ap_start[0] = 1; if_a.ap_done[0] = 1;
        tick(1);
        if_a.ap_done[0] = 0;
        tick(1);
        if_a.ap_start[0] = 0;
        tick(2);
        check("pre_reset_txn", txn_a, 1);
        check("pre_reset_state", state_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_txn", txn_a, 0);
        check("async_reset_busy", busy_a, 0);
        check("async_reset_state", state_a, 0);
        check("async_reset_any_err_b", any_b, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_reset_txn", txn_a, 0);
        check("post_reset_state", state_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
